// File: rtl/ad7124_spi_responder.sv
// rtl/ad7124_spi_responder.sv - AD7124 SPI device emulator: command decode, register file, conversion data with DOUT/RDY
module ad7124_spi_responder #(
    parameter logic [7:0] ID_VALUE = 8'h14
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        spi_sclk_i,
    input  logic        spi_csn_i,
    input  logic        spi_sdi_i,
    output logic        spi_sdo_o,
    output logic        spi_sdo_t,
    input  logic        conv_valid,
    input  logic [23:0] conv_data,
    input  logic [3:0]  conv_chan,
    output logic [15:0] adc_control
);
    typedef enum logic [2:0] {IDLE, CMD, RD, WR, IGNORE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sclk_q, sclk_d;   // [1:0] synchronizer stages, [2] previous synchronized level
    logic [2:0]  csn_q, csn_d;
    logic [1:0]  sdi_q, sdi_d;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  addr_q, addr_d;
    logic [5:0]  width_q, width_d;
    logic        dout_q, dout_d;
    logic        rdy_n_q, rdy_n_d;
    logic [3:0]  chan_q, chan_d;
    logic        pend_q, pend_d;
    logic [23:0] pend_data_q, pend_data_d;
    logic [3:0]  pend_chan_q, pend_chan_d;
    logic [6:0]  ones_q, ones_d;
    logic [23:0] regs_q [64];
    logic [23:0] regs_d [64];

    logic        sclk_rise, sclk_fall, csn_rise, csn_fall, csn_low, sdi_bit;
    logic        serial_rst, rd_done, rd_data, rd_exit;
    logic [7:0]  cmd, status;
    logic [5:0]  cmd_w;
    logic [23:0] rd_val, wr_val;

    function automatic logic [5:0] reg_width(input logic [5:0] a, input logic data_status);
        if (a == 6'h02 && data_status) return 6'd32;
        if (a == 6'h00 || a == 6'h05 || a == 6'h08 || a >= 6'h39) return 6'd8;
        if (a == 6'h01 || a == 6'h04 || (a >= 6'h09 && a <= 6'h20)) return 6'd16;
        return 6'd24;
    endfunction

    function automatic logic [23:0] reg_default(input logic [5:0] a);
        if (a == 6'h07) return 24'h000040;
        if (a == 6'h09) return 24'h008001;
        if (a >= 6'h0A && a <= 6'h18) return 24'h000001;
        if (a >= 6'h19 && a <= 6'h20) return 24'h000860;
        if (a >= 6'h21 && a <= 6'h28) return 24'h060180;
        if (a >= 6'h29 && a <= 6'h30) return 24'h800000;
        if (a >= 6'h31 && a <= 6'h38) return 24'h500000;
        return 24'h000000;
    endfunction

    function automatic logic reg_writable(input logic [5:0] a);
        return !(a == 6'h00 || a == 6'h02 || a == 6'h05 || a == 6'h06 || a == 6'h08 || a >= 6'h39);
    endfunction

    always_comb begin
        sclk_d      = {sclk_q[1:0], spi_sclk_i};
        csn_d       = {csn_q[1:0], spi_csn_i};
        sdi_d       = {sdi_q[0], spi_sdi_i};
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        width_d     = width_q;
        dout_d      = dout_q;
        rdy_n_d     = rdy_n_q;
        chan_d      = chan_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_chan_d = pend_chan_q;
        ones_d      = ones_q;
        regs_d      = regs_q;
        serial_rst  = 1'b0;
        rd_done     = 1'b0;

        sclk_rise = sclk_q[1] & ~sclk_q[2];
        sclk_fall = ~sclk_q[1] & sclk_q[2];
        csn_rise  = csn_q[1] & ~csn_q[2];
        csn_fall  = ~csn_q[1] & csn_q[2];
        csn_low   = ~csn_q[1];
        sdi_bit   = sdi_q[1];

        status = {rdy_n_q, 3'b000, chan_q};
        cmd    = {shift_q[6:0], sdi_bit};
        cmd_w  = reg_width(cmd[5:0], regs_q[1][10]);
        if (cmd[5:0] == 6'h00)      rd_val = {16'h0000, status};
        else if (cmd[5:0] == 6'h05) rd_val = {16'h0000, ID_VALUE};
        else if (cmd[5:0] >= 6'h39) rd_val = 24'h000000;
        else                        rd_val = regs_q[cmd[5:0]];
        wr_val = {shift_q[22:0], sdi_bit} & (24'hFFFFFF >> (6'd24 - width_q));

        if (csn_low) begin
            if (sclk_rise) begin
                if (sdi_bit) begin
                    if (ones_q != 7'd64) ones_d = ones_q + 7'd1;
                    serial_rst = (ones_q == 7'd63);
                end else begin
                    ones_d = 7'd0;
                end
            end
        end else begin
            ones_d = 7'd0;
        end

        case (state_q)
            IDLE: if (csn_fall) begin
                state_d = CMD;
                cnt_d   = 6'd0;
            end
            CMD: if (sclk_rise) begin
                shift_d = {shift_q[30:0], sdi_bit};
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd7) begin
                    addr_d  = cmd[5:0];
                    width_d = cmd_w;
                    cnt_d   = 6'd0;
                    if (cmd[7]) begin
                        state_d = IGNORE;
                    end else if (cmd[6]) begin
                        state_d = RD;
                        dout_d  = rdy_n_q;
                        if (cmd_w == 6'd32) shift_d = {regs_q[2], status};
                        else                shift_d = {rd_val, 8'h00} << (6'd24 - cmd_w);
                    end else begin
                        state_d = WR;
                    end
                end
            end
            // dout_q holds the bit on the pin so it changes only on SCLK falling edges
            RD: if (sclk_fall && cnt_q != width_q) begin
                dout_d  = shift_q[31];
                shift_d = {shift_q[30:0], 1'b0};
                cnt_d   = cnt_q + 6'd1;
            end else if (sclk_rise && cnt_q == width_q) begin
                rd_done = 1'b1;
                state_d = CMD;
                cnt_d   = 6'd0;
            end
            WR: if (sclk_rise) begin
                shift_d = {shift_q[30:0], sdi_bit};
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == width_q - 6'd1) begin
                    if (reg_writable(addr_q)) regs_d[addr_q] = wr_val;
                    state_d = CMD;
                    cnt_d   = 6'd0;
                end
            end
            default: ;
        endcase

        if (serial_rst) state_d = IGNORE;
        if (csn_rise)   state_d = IDLE;

        // A conversion arriving during a DATA read waits so the word being shifted stays coherent
        rd_data = (state_q == RD) && (addr_q == 6'h02);
        rd_exit = rd_data && (state_d != RD);
        if (rd_done && addr_q == 6'h02) rdy_n_d = 1'b1;
        if (rd_exit && pend_q) begin
            regs_d[2] = pend_data_q;
            chan_d    = pend_chan_q;
            rdy_n_d   = 1'b0;
            pend_d    = 1'b0;
        end
        if (conv_valid) begin
            if (rd_data && !rd_exit) begin
                pend_d      = 1'b1;
                pend_data_d = conv_data;
                pend_chan_d = conv_chan;
            end else begin
                regs_d[2] = conv_data;
                chan_d    = conv_chan;
                rdy_n_d   = 1'b0;
            end
        end

        if (serial_rst) begin
            for (int i = 0; i < 64; i++) regs_d[i] = reg_default(6'(i));
            rdy_n_d = 1'b1;
            chan_d  = 4'd0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            sclk_q      <= 3'b111;
            csn_q       <= 3'b111;
            sdi_q       <= 2'b00;
            shift_q     <= 32'd0;
            cnt_q       <= 6'd0;
            addr_q      <= 6'd0;
            width_q     <= 6'd8;
            dout_q      <= 1'b1;
            rdy_n_q     <= 1'b1;
            chan_q      <= 4'd0;
            pend_q      <= 1'b0;
            pend_data_q <= 24'd0;
            pend_chan_q <= 4'd0;
            ones_q      <= 7'd0;
            for (int i = 0; i < 64; i++) regs_q[i] <= reg_default(6'(i));
        end else begin
            state_q     <= state_d;
            sclk_q      <= sclk_d;
            csn_q       <= csn_d;
            sdi_q       <= sdi_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            dout_q      <= dout_d;
            rdy_n_q     <= rdy_n_d;
            chan_q      <= chan_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_chan_q <= pend_chan_d;
            ones_q      <= ones_d;
            for (int i = 0; i < 64; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign spi_sdo_t   = (state_q == IDLE);
    assign spi_sdo_o   = (state_q == IDLE) ? 1'b1 : (state_q == RD) ? dout_q : rdy_n_q;
    assign adc_control = regs_q[1][15:0];

endmodule
